// File: rtl/requant_pkg.sv
// Shared widths and packed layouts for the requantization arbiter:
// the in-flight tag that rides beside the scaler and the output FIFO entry.
package requant_pkg;

    localparam int REQ_N_REQ   = 4;
    localparam int REQ_DATA_W  = 16;
    localparam int REQ_SHIFT_W = 4;
    localparam int REQ_N_CH    = 16;
    localparam int REQ_ID_W    = $clog2(REQ_N_REQ);
    localparam int REQ_CH_W    = $clog2(REQ_N_CH);

    typedef struct packed {
        logic                v;
        logic [REQ_ID_W-1:0] id;
        logic [REQ_CH_W-1:0] ch;
    } tag_t;

    typedef struct packed {
        logic [REQ_DATA_W-1:0] dat;
        logic [REQ_ID_W-1:0]   id;
        logic [REQ_CH_W-1:0]   ch;
    } fifo_entry_t;

endpackage

// File: rtl/requant_out_fifo.sv
// Generic register FIFO with occupancy count; head visible combinationally (0 when empty).
// Latency: write to head 1 cycle; push is never refused, upstream credits must prevent overflow.
module requant_out_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign rd_vld = (cnt_q != '0);
    assign rd_en  = rd_vld & rd_rdy;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en  = wr_vld & (~full | rd_en);
    assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
    assign count  = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_vld && full && !rd_rdy));

endmodule

// File: rtl/requant_arbiter.sv
// Round-robin share of one requant scaler across PE lanes, with shift table, lane/channel tags and result FIFO.
// Latency: grant to out_valid 1+SCALE_LAT cycles; grants stop once SCALE_LAT+2 words are outstanding.
module requant_arbiter
    import requant_pkg::*;
#(
    parameter int N_REQ     = REQ_N_REQ,
    parameter int DATA_W    = REQ_DATA_W,
    parameter int SHIFT_W   = REQ_SHIFT_W,
    parameter int N_CH      = REQ_N_CH,
    parameter int SCALE_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(N_CH)-1:0]    cfg_ch,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ*$clog2(N_CH)-1:0] req_ch,
    output logic [N_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]          sc_din,
    output logic [SHIFT_W-1:0]         sc_shift,
    input  logic [DATA_W-1:0]          sc_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    output logic [$clog2(N_CH)-1:0]    out_ch,
    output logic                       busy
);

    // Tag and FIFO entry layouts come from requant_pkg, so lane, channel and
    // data widths must stay at the package values.
    localparam int ID_W   = $clog2(N_REQ);
    localparam int CH_W   = $clog2(N_CH);
    localparam int D      = SCALE_LAT + 2;
    localparam int CNT_W  = $clog2(D + 1);
    localparam int USED_W = CNT_W + 1;

    logic [SHIFT_W-1:0] shift_tbl_q [N_CH];
    logic [SHIFT_W-1:0] shift_tbl_d [N_CH];
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  sc_din_q, sc_din_d;
    logic [SHIFT_W-1:0] sc_shift_q, sc_shift_d;
    tag_t               tag_q [SCALE_LAT];
    tag_t               tag_d [SCALE_LAT];

    logic               found;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    sel;
    logic [CH_W-1:0]    sel_ch;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [USED_W-1:0]  used;
    logic               credit_ok;
    logic               hs;
    logic               pop;
    logic               fifo_vld;
    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;

    always_comb begin
        found = 1'b0;
        cand  = rr_ptr_q;
        sel   = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = rr_ptr_q + ID_W'(k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign sel_ch = req_ch[sel*CH_W +: CH_W];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < SCALE_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_q[i].v);
        end
    end

    // A pop this cycle frees a slot that a grant may claim in the same cycle.
    assign pop       = fifo_vld & out_ready;
    assign used      = USED_W'(inflight) + USED_W'(fifo_cnt);
    assign credit_ok = used < (USED_W'(D) + USED_W'(pop));
    assign hs        = found & credit_ok & ~rst;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready = N_REQ'(1) << sel;
        end
    end

    always_comb begin
        shift_tbl_d = shift_tbl_q;
        if (cfg_we) begin
            shift_tbl_d[cfg_ch] = cfg_shift;
        end
        rr_ptr_d   = rr_ptr_q;
        sc_din_d   = sc_din_q;
        sc_shift_d = sc_shift_q;
        tag_d[0]   = '0;
        for (int i = 1; i < SCALE_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        // Issue reads the registered table, so a same-cycle write is not seen yet.
        if (hs) begin
            rr_ptr_d   = sel + 1'b1;
            sc_din_d   = req_data[sel*DATA_W +: DATA_W];
            sc_shift_d = shift_tbl_q[sel_ch];
            tag_d[0]   = '{v: 1'b1, id: sel, ch: sel_ch};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                shift_tbl_q[i] <= '0;
            end
            for (int i = 0; i < SCALE_LAT; i++) begin
                tag_q[i] <= '0;
            end
            rr_ptr_q   <= '0;
            sc_din_q   <= '0;
            sc_shift_q <= '0;
        end else begin
            shift_tbl_q <= shift_tbl_d;
            tag_q       <= tag_d;
            rr_ptr_q    <= rr_ptr_d;
            sc_din_q    <= sc_din_d;
            sc_shift_q  <= sc_shift_d;
        end
    end

    assign sc_din   = sc_din_q;
    assign sc_shift = sc_shift_q;

    assign push_entry = '{dat: sc_dout, id: tag_q[SCALE_LAT-1].id, ch: tag_q[SCALE_LAT-1].ch};

    requant_out_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (D)
    ) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (tag_q[SCALE_LAT-1].v),
        .wr_dat (push_entry),
        .rd_vld (fifo_vld),
        .rd_rdy (out_ready),
        .rd_dat (head_entry),
        .count  (fifo_cnt)
    );

    assign out_valid = fifo_vld;
    assign out_data  = head_entry.dat;
    assign out_id    = head_entry.id;
    assign out_ch    = head_entry.ch;
    assign busy      = (inflight != '0) | fifo_vld;

endmodule

// File: tb/tb_requant_arbiter.sv
// Bench for requant_arbiter: rounding scaler model, directed scenarios, then random traffic
// checked against a transaction-level model (outstanding-word queue, shadow shift table).
module tb_requant_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [3:0]  cfg_shift;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [15:0] req_ch;
    logic [3:0]  req_ready;
    logic [15:0] sc_din;
    logic [3:0]  sc_shift;
    logic [15:0] sc_dout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_id;
    logic [3:0]  out_ch;
    logic        busy;

    always #5 clk = ~clk;

    requant_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_shift (cfg_shift),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ch    (req_ch),
        .req_ready (req_ready),
        .sc_din    (sc_din),
        .sc_shift  (sc_shift),
        .sc_dout   (sc_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ch    (out_ch),
        .busy      (busy)
    );

    function automatic logic [15:0] rnd_shift(input logic [15:0] din, input int s);
        int v;
        v = $signed(din);
        if (s > 0) v = v + (1 << (s - 1));
        v = v >>> s;
        return v[15:0];
    endfunction

    assign sc_dout = rnd_shift(sc_din, int'(sc_shift));

    typedef struct {
        logic [15:0] dat;
        int          id;
        int          ch;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          m_tbl[16];
    int          m_rr;
    logic [15:0] m_sc_din;
    logic [3:0]  m_sc_shift;
    int          cyc;
    int          dut_hs;
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = 0;
        m_rr       = 0;
        m_sc_din   = '0;
        m_sc_shift = '0;
        q.delete();
    endtask

    // One clock of the reference: a word accepted at cycle t is visible from t+2,
    // and a grant needs fewer than 3 accepted-but-unpopped words after this cycle's pop.
    task automatic model_step();
        bit         exp_ov;
        bit         pop;
        bit         found;
        int         sel;
        int         l;
        logic [3:0] exp_rdy;
        exp_t       e;
        if (rst) begin
            check_eq("rst_req_ready", req_ready, 4'h0);
            check_eq("rst_out_valid", out_valid, 1'b0);
            check_eq("rst_busy", busy, 1'b0);
            model_reset();
            return;
        end
        exp_ov = (q.size() != 0) && (q[0].t <= cyc - 2);
        check_eq("out_valid", out_valid, exp_ov);
        check_eq("busy", busy, q.size() != 0);
        check_eq("sc_din", sc_din, m_sc_din);
        check_eq("sc_shift", sc_shift, m_sc_shift);
        pop = exp_ov && out_ready;
        if (exp_ov) begin
            check_eq("out_data", out_data, q[0].dat);
            check_eq("out_id", out_id, q[0].id);
            check_eq("out_ch", out_ch, q[0].ch);
        end
        found = 0;
        sel   = 0;
        for (int k = 0; k < 4; k++) begin
            l = (m_rr + k) % 4;
            if (!found && req_valid[l]) begin
                found = 1;
                sel   = l;
            end
        end
        exp_rdy = (found && (q.size() - int'(pop) < 3)) ? 4'(1 << sel) : 4'h0;
        check_eq("req_ready", req_ready, exp_rdy);
        if ((req_ready & req_valid) != 0) dut_hs++;
        if (pop) void'(q.pop_front());
        if (exp_rdy != 0) begin
            e.ch  = int'(req_ch[sel*4 +: 4]);
            e.id  = sel;
            e.dat = rnd_shift(req_data[sel*16 +: 16], m_tbl[e.ch]);
            e.t   = cyc;
            q.push_back(e);
            m_sc_din   = req_data[sel*16 +: 16];
            m_sc_shift = 4'(m_tbl[e.ch]);
            m_rr       = (sel + 1) % 4;
        end
        if (cfg_we) m_tbl[cfg_ch] = int'(cfg_shift);
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [15:0] d, input logic [3:0] c);
        req_valid[i]       = v;
        req_data[i*16 +: 16] = d;
        req_ch[i*4 +: 4]   = c;
    endtask

    task automatic rand_lanes(input logic [3:0] v);
        for (int i = 0; i < 4; i++) set_lane(i, v[i], 16'($urandom), 4'($urandom));
    endtask

    initial begin
        int h0;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        dut_hs    = 0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_shift = '0;
        req_valid = 4'hF;
        req_data  = '0;
        req_ch    = '0;
        out_ready = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_req_ready", req_ready, 4'h0);
        check_eq("reset_sc_din", sc_din, 16'h0);
        check_eq("reset_sc_shift", sc_shift, 4'h0);
        check_eq("reset_out_valid", out_valid, 1'b0);
        check_eq("reset_out_data", out_data, 16'h0);
        check_eq("reset_out_id", out_id, 2'h0);
        check_eq("reset_out_ch", out_ch, 4'h0);
        check_eq("reset_busy", busy, 1'b0);
        req_valid = 4'h0;
        rst = 1'b0;

        // Basic issue: ch3 shift 4, lane0 0x0FF0.
        cfg_we = 1'b1; cfg_ch = 4'd3; cfg_shift = 4'd4;
        tick();
        cfg_we = 1'b0;
        set_lane(0, 1'b1, 16'h0FF0, 4'd3);
        tick();
        req_valid = 4'h0;
        check_eq("basic_sc_din", sc_din, 16'h0FF0);
        check_eq("basic_sc_shift", sc_shift, 4'd4);
        tick();
        check_eq("basic_out_valid", out_valid, 1'b1);
        check_eq("basic_out_data", out_data, 16'h00FF);
        check_eq("basic_out_id", out_id, 2'd0);
        check_eq("basic_out_ch", out_ch, 4'd3);
        tick();

        // All lanes streaming with the sink open: one grant per cycle.
        h0 = dut_hs;
        for (int n = 0; n < 12; n++) begin
            rand_lanes(4'hF);
            tick();
        end
        check_eq("stream_grants", dut_hs - h0, 12);
        req_valid = 4'h0;
        repeat (3) tick();

        // Sink stalled: exactly D grants, then nothing until the drain starts.
        out_ready = 1'b0;
        h0 = dut_hs;
        for (int n = 0; n < 6; n++) begin
            rand_lanes(4'hF);
            tick();
        end
        check_eq("stall_grants", dut_hs - h0, 3);
        check_eq("stall_req_ready", req_ready, 4'h0);
        out_ready = 1'b1;
        h0 = dut_hs;
        for (int n = 0; n < 6; n++) begin
            rand_lanes(4'hF);
            tick();
        end
        check_eq("resume_grants", dut_hs - h0, 6);
        req_valid = 4'h0;
        repeat (3) tick();

        // Table write racing an issue on the same channel.
        cfg_we = 1'b1; cfg_ch = 4'd5; cfg_shift = 4'd1;
        set_lane(2, 1'b1, 16'h1235, 4'd5);
        tick();
        cfg_we = 1'b0;
        set_lane(2, 1'b1, 16'h8FF9, 4'd5);
        tick();
        req_valid = 4'h0;
        check_eq("race_old_shift", out_data, 16'h1235);
        tick();
        check_eq("race_new_shift", out_data, 16'hC7FD);
        check_eq("race_new_id", out_id, 2'd2);
        tick();

        // Reset with two words parked in the FIFO.
        out_ready = 1'b0;
        set_lane(1, 1'b1, 16'h4444, 4'd3);
        tick();
        tick();
        req_valid = 4'h0;
        tick();
        check_eq("pre_rst_out_valid", out_valid, 1'b1);
        req_valid = 4'hF;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_req_ready", req_ready, 4'h0);
        req_valid = 4'h0;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        set_lane(3, 1'b1, 16'h0FF0, 4'd3);
        tick();
        req_valid = 4'h0;
        tick();
        check_eq("post_rst_out_data", out_data, 16'h0FF0);
        check_eq("post_rst_out_id", out_id, 2'd3);
        tick();

        // Random traffic with random backpressure and table updates.
        for (int n = 0; n < 400; n++) begin
            rand_lanes(4'($urandom));
            out_ready = ($urandom % 4) != 0;
            cfg_we    = ($urandom % 8) == 0;
            cfg_ch    = 4'($urandom);
            cfg_shift = 4'($urandom);
            tick();
        end
        cfg_we    = 1'b0;
        req_valid = 4'h0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() != 0; n++) tick();
        check_eq("drain_left", q.size(), 0);
        tick();
        check_eq("idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
